// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI round-robin arbiter.
// PCI_ARB_PARK_EN adds the PARK state (bus parking on the last owner).
package pci_arb_pkg;

  localparam int NUM_REQ_C = 8;
  localparam int IDX_W     = 3;
  localparam int TMR_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_BUSY      = 3'd2,
    ST_WAIT_IDLE = 3'd3
`ifdef PCI_ARB_PARK_EN
    ,
    ST_PARK      = 3'd4
`endif
  } arb_state_e;

endpackage

// File: rtl/pci_rr_arbiter_if.sv
// PCI arbitration bus bundle: requests and FRAME#/IRDY# in, grants and owner out.
// Handshake: an agent holds REQ_N[i] low until it has run FRAME_N under GNT_N[i] low;
// the arbiter only moves the grant to another agent after a cycle with GNT_N all high.
interface pci_rr_arbiter_if;
  import pci_arb_pkg::*;

  logic [NUM_REQ_C-1:0] REQ_N;
  logic                 FRAME_N;
  logic                 IRDY_N;
  logic [NUM_REQ_C-1:0] GNT_N;
  logic [IDX_W-1:0]     OWNER;
  logic                 OWNER_VLD;
  arb_state_e           state_dbg;

  modport master (
    input  REQ_N, FRAME_N, IRDY_N,
    output GNT_N, OWNER, OWNER_VLD, state_dbg
  );

  modport slave (
    output REQ_N, FRAME_N, IRDY_N,
    input  GNT_N, OWNER, OWNER_VLD, state_dbg
  );

endinterface

// File: rtl/pci_arb_rr_pick.sv
// Combinational round-robin picker: first requesting agent above last_ptr, wrapping.
module pci_arb_rr_pick
  import pci_arb_pkg::*;
(
  input  logic [NUM_REQ_C-1:0] req_n,
  input  logic [IDX_W-1:0]     last_ptr,
  output logic [IDX_W-1:0]     pick,
  output logic                 any_req
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    pick    = last_ptr;
    any_req = 1'b0;
    idx     = '0;
    for (int i = NUM_REQ_C; i >= 1; i--) begin
      idx = last_ptr + IDX_W'(i);
      if (!req_n[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// PCI round-robin bus arbiter with grant timeout and idle-bus gap between owners.
// Define PCI_ARB_PARK_EN to park the grant on the last owner when nobody requests.
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_REQ     = 8,
  parameter int GNT_TIMEOUT = 16
) (
  input logic               CLK,
  input logic               RST,
  pci_rr_arbiter_if.master  bus
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_n_q, gnt_n_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               owner_vld_q, owner_vld_d;
  logic [IDX_W-1:0]   last_ptr_q, last_ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [NUM_REQ-1:0] owner_mask;
  logic               own_req;
  logic               other_req;

  pci_arb_rr_pick u_pick (
    .req_n    (bus.REQ_N),
    .last_ptr (last_ptr_q),
    .pick     (pick),
    .any_req  (any_req)
  );

  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    own_req             = !bus.REQ_N[owner_q];
    other_req           = |(~bus.REQ_N & ~owner_mask);
  end

  always_comb begin
    state_d     = state_q;
    gnt_n_d     = gnt_n_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    last_ptr_d  = last_ptr_q;
    timer_d     = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_n_d       = '1;
          gnt_n_d[pick] = 1'b0;
          owner_d       = pick;
          owner_vld_d   = 1'b1;
          timer_d       = '0;
          state_d       = ST_GRANT;
        end
`ifdef PCI_ARB_PARK_EN
        else begin
          gnt_n_d             = '1;
          gnt_n_d[last_ptr_q] = 1'b0;
          owner_d             = last_ptr_q;
          owner_vld_d         = 1'b1;
          state_d             = ST_PARK;
        end
`endif
      end
      ST_GRANT: begin
        if (!bus.FRAME_N) begin
          last_ptr_d = owner_q;
          state_d    = ST_BUSY;
        end else if (!own_req) begin
          gnt_n_d     = '1;
          owner_vld_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (timer_q == TMR_W'(GNT_TIMEOUT - 1)) begin
          // A silent master is skipped so it cannot starve the others.
          gnt_n_d     = '1;
          owner_vld_d = 1'b0;
          last_ptr_d  = owner_q;
          state_d     = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (other_req || !own_req) begin
          gnt_n_d = '1;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (bus.FRAME_N && bus.IRDY_N) begin
          owner_vld_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`ifdef PCI_ARB_PARK_EN
      ST_PARK: begin
        if (!bus.FRAME_N) begin
          last_ptr_d = owner_q;
          state_d    = ST_BUSY;
        end else if (own_req) begin
          timer_d = '0;
          state_d = ST_GRANT;
        end else if (other_req) begin
          gnt_n_d     = '1;
          owner_vld_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: begin
        gnt_n_d     = '1;
        owner_vld_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      gnt_n_q     <= '1;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      last_ptr_q  <= '1;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      gnt_n_q     <= gnt_n_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      last_ptr_q  <= last_ptr_d;
      timer_q     <= timer_d;
    end
  end

  assign bus.GNT_N     = gnt_n_q;
  assign bus.OWNER     = owner_q;
  assign bus.OWNER_VLD = owner_vld_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Directed bench for pci_rr_arbiter: grant order, timeout, preemption, reset, parking.
module tb_pci_rr_arbiter;
  import pci_arb_pkg::*;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;
  logic [7:0] prev_gnt;

  pci_rr_arbiter_if bus ();

  pci_rr_arbiter #(.NUM_REQ(8), .GNT_TIMEOUT(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance n edges; after each, the grant may only go idle or stay with one agent.
  task automatic step(input int n);
    logic ok;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      ok = ($countones(~bus.GNT_N) <= 1) &&
           (prev_gnt == 8'hFF || bus.GNT_N == 8'hFF || bus.GNT_N == prev_gnt);
      chk("gnt_handover", {7'd0, ok}, 8'h01);
      prev_gnt = bus.GNT_N;
    end
  endtask

  initial begin
    logic [7:0] exp_gnt;
    logic [2:0] e;
    n_tests     = 0;
    n_fail      = 0;
    prev_gnt    = 8'hFF;
    RST         = 1'b1;
    bus.REQ_N   = 8'hFE;
    bus.FRAME_N = 1'b1;
    bus.IRDY_N  = 1'b1;
    step(2);
    chk("rst_gnt", bus.GNT_N, 8'hFF);
    chk("rst_owner", {5'd0, bus.OWNER}, 8'h00);
    chk("rst_vld", {7'd0, bus.OWNER_VLD}, 8'h00);
    chk("rst_state", {5'd0, bus.state_dbg}, {5'd0, ST_IDLE});

    // First grant one clock after a request from reset.
    RST = 1'b0;
    step(1);
    chk("first_gnt", bus.GNT_N, 8'hFE);
    chk("first_owner", {5'd0, bus.OWNER}, 8'h00);
    chk("first_vld", {7'd0, bus.OWNER_VLD}, 8'h01);

    // Everyone requests; each runs one transaction: order 0..7 then 0.
    bus.REQ_N = 8'h00;
    for (int k = 0; k < 8; k++) begin
      e = 3'(k);
      exp_gnt = ~(8'h01 << e);
      chk("rr_gnt", bus.GNT_N, exp_gnt);
      chk("rr_owner", {5'd0, bus.OWNER}, {5'd0, e});
      bus.FRAME_N = 1'b0;
      bus.IRDY_N  = 1'b0;
      step(1);
      chk("rr_busy_gnt", bus.GNT_N, exp_gnt);
      step(1);
      chk("rr_revoke", bus.GNT_N, 8'hFF);
      chk("rr_drain_vld", {7'd0, bus.OWNER_VLD}, 8'h01);
      bus.FRAME_N = 1'b1;
      bus.IRDY_N  = 1'b1;
      step(1);
      chk("rr_idle_gnt", bus.GNT_N, 8'hFF);
      chk("rr_idle_vld", {7'd0, bus.OWNER_VLD}, 8'h00);
      step(1);
    end
    chk("rr_wrap_gnt", bus.GNT_N, 8'hFE);

    // Withdrawn request: grant dropped, last_ptr stays at 7.
    bus.REQ_N = 8'hFF;
    step(1);
    chk("wd_gnt", bus.GNT_N, 8'hFF);
    chk("wd_vld", {7'd0, bus.OWNER_VLD}, 8'h00);
    bus.REQ_N = 8'hF0;
    step(1);
    chk("wd_next_gnt", bus.GNT_N, 8'hFE);
    bus.REQ_N = 8'hFF;
    step(1);

    // Timeout: agent 3 never drives FRAME_N; agent 5 follows.
    bus.REQ_N = 8'hD7;
    step(1);
    chk("to_gnt", bus.GNT_N, 8'hF7);
    chk("to_owner", {5'd0, bus.OWNER}, 8'h03);
    step(15);
    chk("to_held15", bus.GNT_N, 8'hF7);
    step(1);
    chk("to_revoked", bus.GNT_N, 8'hFF);
    chk("to_vld", {7'd0, bus.OWNER_VLD}, 8'h00);
    step(1);
    chk("to_next_gnt", bus.GNT_N, 8'hDF);
    chk("to_next_owner", {5'd0, bus.OWNER}, 8'h05);

    // Preemption: agent 2 busy, agent 6 requests.
    bus.REQ_N = 8'hFF;
    step(1);
    bus.REQ_N = 8'hFB;
    step(1);
    chk("pre_gnt2", bus.GNT_N, 8'hFB);
    bus.FRAME_N = 1'b0;
    bus.IRDY_N  = 1'b0;
    step(1);
    bus.REQ_N = 8'hBB;
    step(1);
    chk("pre_revoke", bus.GNT_N, 8'hFF);
    chk("pre_owner", {5'd0, bus.OWNER}, 8'h02);
    step(1);
    chk("pre_wait_frame", bus.GNT_N, 8'hFF);
    bus.FRAME_N = 1'b1;
    step(1);
    chk("pre_wait_irdy", bus.GNT_N, 8'hFF);
    chk("pre_wait_vld", {7'd0, bus.OWNER_VLD}, 8'h01);
    bus.IRDY_N = 1'b1;
    step(1);
    chk("pre_idle", bus.GNT_N, 8'hFF);
    step(1);
    chk("pre_gnt6", bus.GNT_N, 8'hBF);

    // Reset during agent 5's transaction.
    bus.REQ_N = 8'hFF;
    step(1);
    bus.REQ_N = 8'hDF;
    step(1);
    chk("rb_gnt5", bus.GNT_N, 8'hDF);
    bus.FRAME_N = 1'b0;
    step(1);
    RST = 1'b1;
    step(1);
    chk("rb_gnt", bus.GNT_N, 8'hFF);
    chk("rb_vld", {7'd0, bus.OWNER_VLD}, 8'h00);
    RST         = 1'b0;
    bus.FRAME_N = 1'b1;
    bus.IRDY_N  = 1'b1;
    bus.REQ_N   = 8'hBE;
    step(1);
    chk("rb_after_gnt", bus.GNT_N, 8'hFE);
    bus.REQ_N = 8'hFF;
    step(1);

`ifdef PCI_ARB_PARK_EN
    // Agent 4 transaction, then park on 4; agent 1 takes over via an idle cycle.
    bus.REQ_N = 8'hEF;
    step(1);
    chk("pk_gnt4", bus.GNT_N, 8'hEF);
    bus.FRAME_N = 1'b0;
    step(1);
    bus.REQ_N = 8'hFF;
    step(1);
    chk("pk_release", bus.GNT_N, 8'hFF);
    bus.FRAME_N = 1'b1;
    step(2);
    chk("pk_parked", bus.GNT_N, 8'hEF);
    chk("pk_owner", {5'd0, bus.OWNER}, 8'h04);
    chk("pk_vld", {7'd0, bus.OWNER_VLD}, 8'h01);
    bus.REQ_N = 8'hFD;
    step(1);
    chk("pk_gap", bus.GNT_N, 8'hFF);
    step(1);
    chk("pk_gnt1", bus.GNT_N, 8'hFD);
`else
    step(3);
    chk("np_nogrant", bus.GNT_N, 8'hFF);
    chk("np_vld", {7'd0, bus.OWNER_VLD}, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_rr_arbiter.md
PCI_RR_ARBITER -- requirements
Module: pci_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 8, SHALL set the number of PCI request/grant pairs; fixed at 8 in this release.
REQ-002 Parameter GNT_TIMEOUT, default 16, SHALL set the clocks a granted master has to assert FRAME_N before its grant is revoked.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 REQ_N  input  8  SHALL be the active-low bus requests, one per agent.
REQ-006 FRAME_N  input  1  SHALL be the active-low PCI FRAME#, sampled at CLK.
REQ-007 IRDY_N  input  1  SHALL be the active-low PCI IRDY#, sampled at CLK.
REQ-008 GNT_N  output  8  SHALL be the active-low grants, registered, at most one bit low.
REQ-009 OWNER  output  3  SHALL be the binary index of the currently granted agent, registered.
REQ-010 OWNER_VLD  output  1  SHALL be high while OWNER names a granted or bus-owning agent.

Function
REQ-011 States SHALL be IDLE, GRANT, BUSY, WAIT_IDLE, plus PARK when PCI_ARB_PARK_EN is defined.
REQ-012 Selection SHALL be round-robin: the first agent with REQ_N low searching upward from last_ptr+1, wrapping 7->0.
REQ-013 IDLE: any REQ_N low -> next cycle GNT_N[pick]=0, OWNER=pick, OWNER_VLD=1, timer=0, state GRANT (grant latency 1 clock).
REQ-014 GRANT: FRAME_N sampled low -> BUSY, last_ptr=OWNER; GNT_N unchanged.
REQ-015 GRANT: REQ_N[OWNER] high (withdrawn) and FRAME_N high -> GNT_N all high, OWNER_VLD=0, IDLE; last_ptr unchanged.
REQ-016 GRANT: timer reaches GNT_TIMEOUT with FRAME_N never low -> GNT_N all high, OWNER_VLD=0, last_ptr=OWNER (agent skipped), IDLE.
REQ-017 BUSY: another agent's REQ_N low, or REQ_N[OWNER] high -> GNT_N all high next cycle, WAIT_IDLE; OWNER_VLD stays 1 (owner still drives bus).
REQ-018 WAIT_IDLE: FRAME_N and IRDY_N both sampled high -> OWNER_VLD=0, IDLE; guarantees at least one clock with all GNT_N high between owners.
REQ-019 GNT_N SHALL never change from one agent low directly to a different agent low in one edge.
REQ-020 Simultaneous requests SHALL be resolved solely by REQ-012; a request withdrawn in the same cycle it would win SHALL not be granted.
REQ-021 Timer SHALL be 5 bits, saturating, cleared on every entry to GRANT.

Reset
REQ-022 RST high at an edge SHALL force GNT_N=8'hFF, OWNER=0, OWNER_VLD=0, last_ptr=7, timer=0, state IDLE, regardless of state or bus activity.
REQ-023 After RST deasserts, agent 0 SHALL have highest priority; a reset mid-transaction SHALL drop the grant with no drain wait.

Configuration
REQ-024 Macro PCI_ARB_PARK_EN defined: IDLE with no request -> PARK, GNT_N[last_ptr]=0, OWNER=last_ptr, OWNER_VLD=1, no timeout.
REQ-025 PARK: FRAME_N low -> BUSY; REQ_N[OWNER] low -> GRANT with grant held (no gap); other agent's REQ_N low -> GNT_N all high, IDLE.
REQ-026 Macro undefined: no PARK state; GNT_N=8'hFF whenever no agent requests.

Structure
REQ-027 Package pci_arb_pkg SHALL hold the state enum, NUM_REQ_C, IDX_W (=3) and the timeout width constant.
REQ-028 Sub-module pci_arb_rr_pick SHALL hold the combinational round-robin picker (inputs REQ_N, last_ptr; outputs pick index, any_req).

Verification
REQ-029 Reset, REQ_N=8'hFE -> GNT_N=8'hFE one clock later, OWNER=0, OWNER_VLD=1.
REQ-030 REQ_N=8'h00 held, each master runs one FRAME_N transaction -> grants in order 0,1,...,7,0 with one all-high GNT_N cycle between owners.
REQ-031 REQ_N[3] low, FRAME_N held high -> GNT_N[3] revoked after 16 clocks; with REQ_N[5] also low, agent 5 granted next.
REQ-032 Agent 2 in BUSY, REQ_N[6] falls -> GNT_N=8'hFF next clock; GNT_N[6] low only after FRAME_N and IRDY_N both high.
REQ-033 PCI_ARB_PARK_EN defined, all REQ_N high after agent 4 transaction -> GNT_N=8'hEF parked; REQ_N[1] falls -> 8'hFF then 8'hFD.
REQ-034 RST pulsed during BUSY of agent 5 -> GNT_N=8'hFF, OWNER_VLD=0 next edge; next pick starts from agent 0.
